// File: rtl/tetris_pkg.sv
// Shared playfield constants, request opcodes and the board controller state encoding.
package tetris_pkg;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 20;
  localparam int BOARD_CELLS = BOARD_W * BOARD_H;

  localparam logic OP_CHECK = 1'b0;
  localparam logic OP_LOCK  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/board_line_shift.sv
// Combinational row-full detect and collapse: rows 1..row take rows 0..row-1, row 0 is emptied.
module board_line_shift
  import tetris_pkg::*;
#(
  parameter int W     = BOARD_W,
  parameter int H     = BOARD_H,
  parameter int ROW_W = $clog2(H)
) (
  input  logic [W*H-1:0]   board,
  input  logic [ROW_W-1:0] row,
  output logic             full,
  output logic [W*H-1:0]   collapsed
);

  always_comb begin
    full      = &board[int'(row)*W +: W];
    collapsed = board;
    // Rows below the examined one are untouched; row 0 refills with empties.
    for (int r = 1; r < H; r++) begin
      if (r <= int'(row)) begin
        collapsed[r*W +: W] = board[(r-1)*W +: W];
      end
    end
    collapsed[W-1:0] = '0;
  end

endmodule

// File: rtl/board_ctrl.sv
// Playfield store: CHECK tests four cells for collision, LOCK writes them then scans and collapses full lines.
module board_ctrl
  import tetris_pkg::*;
#(
  parameter int W     = BOARD_W,
  parameter int H     = BOARD_H,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_op,
  input  logic [7:0]         L_1,
  input  logic [7:0]         L_2,
  input  logic [7:0]         L_3,
  input  logic [7:0]         L_4,
  output logic               req_ready,
  input  logic               clear_board,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [2:0]         rsp_lines,
  output logic [CNT_W-1:0]   lines_total,
  output logic               busy,
  output logic [W*H-1:0]     board
);

  localparam int         CELLS    = W * H;
  localparam int         ROW_W    = $clog2(H);
  localparam logic [7:0] CELL_LIM = 8'(CELLS);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE and the indices are captured on that edge alone.

  state_t               state, state_n;
  logic [W*H-1:0]       board_n;
  logic [ROW_W-1:0]     row_ptr, row_ptr_n;
  logic [2:0]           clr_cnt, clr_cnt_n;
  logic [3:0][7:0]      idx_q, idx_n;
  logic                 rsp_valid_n, rsp_hit_n;
  logic [2:0]           rsp_lines_n;
  logic [CNT_W-1:0]     lines_total_n;
  logic [CNT_W:0]       total_sum;
  logic                 hit_any;
  logic                 row_full;
  logic [W*H-1:0]       collapsed;
  logic [3:0][7:0]      req_idx;

  assign req_idx   = {L_4, L_3, L_2, L_1};
  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;

  board_line_shift #(
    .W     (W),
    .H     (H),
    .ROW_W (ROW_W)
  ) u_line_shift (
    .board     (board),
    .row       (row_ptr),
    .full      (row_full),
    .collapsed (collapsed)
  );

  always_comb begin
    hit_any = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (req_idx[n] >= CELL_LIM) begin
        hit_any = 1'b1;
      end else if (board[req_idx[n]]) begin
        hit_any = 1'b1;
      end
    end
  end

  assign total_sum = {1'b0, lines_total} + (CNT_W+1)'(clr_cnt);

  always_comb begin
    state_n       = state;
    board_n       = board;
    row_ptr_n     = row_ptr;
    clr_cnt_n     = clr_cnt;
    idx_n         = idx_q;
    rsp_valid_n   = 1'b0;
    rsp_hit_n     = rsp_hit;
    rsp_lines_n   = rsp_lines;
    lines_total_n = lines_total;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_CHECK) begin
            rsp_valid_n = 1'b1;
            rsp_hit_n   = hit_any;
            rsp_lines_n = '0;
          end else begin
            idx_n   = req_idx;
            state_n = ST_LOCK;
          end
        end else if (clear_board) begin
          board_n       = '0;
          lines_total_n = '0;
        end
      end
      ST_LOCK: begin
        // Out-of-range indices are dropped; duplicates simply OR in.
        for (int n = 0; n < 4; n++) begin
          if (idx_q[n] < CELL_LIM) begin
            board_n[idx_q[n]] = 1'b1;
          end
        end
        row_ptr_n = ROW_W'(H - 1);
        clr_cnt_n = '0;
        state_n   = ST_SCAN;
      end
      ST_SCAN: begin
        // A full row collapses and the pointer holds so the shifted-in row is examined next.
        if (row_full) begin
          board_n   = collapsed;
          clr_cnt_n = clr_cnt + 3'd1;
        end else if (row_ptr == '0) begin
          state_n     = ST_DONE;
          rsp_valid_n = 1'b1;
          rsp_hit_n   = 1'b0;
          rsp_lines_n = clr_cnt;
        end else begin
          row_ptr_n = row_ptr - 1'b1;
        end
      end
      ST_DONE: begin
        lines_total_n = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
        state_n       = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board       <= '0;
      row_ptr     <= '0;
      clr_cnt     <= '0;
      idx_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_lines   <= '0;
      lines_total <= '0;
    end else begin
      board       <= board_n;
      row_ptr     <= row_ptr_n;
      clr_cnt     <= clr_cnt_n;
      idx_q       <= idx_n;
      rsp_valid   <= rsp_valid_n;
      rsp_hit     <= rsp_hit_n;
      rsp_lines   <= rsp_lines_n;
      lines_total <= lines_total_n;
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: collision checks, locks with 0/1/4 line clears, clear_board and reset abort.
module tb_board_ctrl;
  import tetris_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_op;
  logic [7:0]       l1, l2, l3, l4;
  logic             req_ready;
  logic             clear_board;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [2:0]       rsp_lines;
  logic [CNT_W-1:0] lines_total;
  logic             busy;
  logic [199:0]     board;

  int n_checks = 0;
  int n_errors = 0;

  logic [199:0] exp_b;
  int           lat;
  logic         hit;
  logic [2:0]   lines;
  int           cells[$];
  int           seen;

  board_ctrl #(.W(10), .H(20), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .L_1         (l1),
    .L_2         (l2),
    .L_3         (l3),
    .L_4         (l4),
    .req_ready   (req_ready),
    .clear_board (clear_board),
    .rsp_valid   (rsp_valid),
    .rsp_hit     (rsp_hit),
    .rsp_lines   (rsp_lines),
    .lines_total (lines_total),
    .busy        (busy),
    .board       (board)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: presents one request, then waits (bounded) for the response pulse.
  // lat counts edges from acceptance to the edge sampling rsp_valid; 0 means none arrived.
  task automatic send(input logic op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d,
                      output int lat_o, output logic hit_o, output logic [2:0] lines_o);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    l1 = a; l2 = b; l3 = c; l4 = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat_o   = 0;
    hit_o   = 1'bx;
    lines_o = 'x;
    for (int i = 1; i <= 60; i++) begin
      if (rsp_valid) begin
        lat_o   = i;
        hit_o   = rsp_hit;
        lines_o = rsp_lines;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic preload(input int q[$]);
    int         l;
    logic       h;
    logic [2:0] n;
    while (q.size() % 4 != 0) q.push_back(255);
    for (int g = 0; g < q.size() / 4; g++) begin
      send(OP_LOCK, 8'(q[4*g]), 8'(q[4*g+1]), 8'(q[4*g+2]), 8'(q[4*g+3]), l, h, n);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_board = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_board = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = OP_CHECK; clear_board = 1'b0;
    l1 = '0; l2 = '0; l3 = '0; l4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_board", board, '0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_total", lines_total, '0);
    rst = 1'b0;

    // CHECK on empty board, in and out of bounds
    send(OP_CHECK, 8'd4, 8'd5, 8'd14, 8'd15, lat, hit, lines);
    check("chk_empty_lat", lat, 1);
    check("chk_empty_hit", hit, 1'b0);
    check("chk_empty_lines", lines, 3'd0);
    send(OP_CHECK, 8'd195, 8'd196, 8'd199, 8'd200, lat, hit, lines);
    check("chk_oob_hit", hit, 1'b1);
    send(OP_CHECK, 8'd199, 8'd199, 8'd199, 8'd199, lat, hit, lines);
    check("chk_last_cell_hit", hit, 1'b0);

    // LOCK with no lines
    send(OP_LOCK, 8'd4, 8'd5, 8'd14, 8'd15, lat, hit, lines);
    check("lock0_lat", lat, 22);
    check("lock0_lines", lines, 3'd0);
    check("lock0_hit", hit, 1'b0);
    check("lock0_busy_in_done", busy, 1'b1);
    @(negedge clk);
    check("lock0_ready_after", req_ready, 1'b1);
    check("lock0_rsp_drop", rsp_valid, 1'b0);
    exp_b = '0;
    exp_b[4] = 1'b1; exp_b[5] = 1'b1; exp_b[14] = 1'b1; exp_b[15] = 1'b1;
    check("lock0_board", board, exp_b);
    check("lock0_total", lines_total, '0);
    send(OP_CHECK, 8'd14, 8'd24, 8'd34, 8'd44, lat, hit, lines);
    check("chk_overlap_hit", hit, 1'b1);
    send(OP_CHECK, 8'd6, 8'd24, 8'd34, 8'd44, lat, hit, lines);
    check("chk_clear_cells_hit", hit, 1'b0);

    // clear_board together with a request: the request wins
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_CHECK; clear_board = 1'b1;
    l1 = 8'd4; l2 = 8'd100; l3 = 8'd101; l4 = 8'd102;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; clear_board = 1'b0;
    check("req_wins_valid", rsp_valid, 1'b1);
    check("req_wins_hit", rsp_hit, 1'b1);
    check("req_wins_board", board, exp_b);

    pulse_clear();
    check("clear_idle_board", board, '0);

    // One-line clear: row 19 cols 0-5, row 18 cols 0-5 and 8
    cells = {190, 191, 192, 193, 194, 195, 180, 181, 182, 183, 184, 185, 188};
    preload(cells);
    send(OP_LOCK, 8'd196, 8'd197, 8'd198, 8'd199, lat, hit, lines);
    check("lock1_lat", lat, 23);
    check("lock1_lines", lines, 3'd1);
    @(negedge clk);
    exp_b = '0;
    for (int c = 0; c < 6; c++) exp_b[190 + c] = 1'b1;
    exp_b[198] = 1'b1;
    check("lock1_board", board, exp_b);
    check("lock1_row0", board[9:0], 10'd0);
    check("lock1_total", lines_total, 16'd1);

    pulse_clear();
    check("clear_board_zero", board, '0);
    check("clear_total_zero", lines_total, '0);

    // Four-line clear: rows 16-19 full except column 9
    cells.delete();
    for (int r = 16; r < 20; r++)
      for (int c = 0; c < 9; c++) cells.push_back(r * 10 + c);
    preload(cells);
    send(OP_LOCK, 8'd169, 8'd179, 8'd189, 8'd199, lat, hit, lines);
    check("lock4_lat", lat, 26);
    check("lock4_lines", lines, 3'd4);
    @(negedge clk);
    check("lock4_board", board, '0);
    check("lock4_total", lines_total, 16'd4);

    // clear_board while busy is ignored
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LOCK;
    l1 = 8'd0; l2 = 8'd1; l3 = 8'd2; l4 = 8'd250;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; clear_board = 1'b1;
    check("busy_ready_low", req_ready, 1'b0);
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    clear_board = 1'b0;
    check("busy_clear_rsp", seen, 1);
    @(negedge clk);
    exp_b = '0;
    exp_b[0] = 1'b1; exp_b[1] = 1'b1; exp_b[2] = 1'b1;
    check("busy_clear_board", board, exp_b);
    check("busy_clear_total", lines_total, 16'd4);

    // Reset abort at edge k+10 of a LOCK
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LOCK;
    l1 = 8'd10; l2 = 8'd11; l3 = 8'd12; l4 = 8'd13;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_board", board, '0);
    check("abort_ready", req_ready, 1'b1);
    check("abort_total", lines_total, '0);
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_rsp", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
